gpio_cfg_ctrl: RTL and testbench
================================

Name: gpio_cfg_ctrl

Overview:
Runtime configuration controller for the 25 bidirectional GPIO pads. It accepts 32-bit serial command frames clocked on the system clock and holds the per-pad direction, pull-enable and output-data registers that drive the pad cells. It also provides synchronised readback of any register, including live pad inputs. It sits between the padframe GPIO cells and the design top module, replacing tie-off GPIO configuration with software-controllable state.

Parameters:
N_GPIO, 25, number of GPIO pads managed (data field width)
HDR_W, 7, command header width in bits (frame length = HDR_W + N_GPIO = 32)

Ports:
clk  input  1  system clock (output of the clock mux)
rst  input  1  asynchronous, active-high reset
cfg_cs  input  1  frame select, active high; one bit sampled per clk while high
cfg_di  input  1  serial command/data in, MSB first
cfg_do  output  1  serial read data out
cfg_done  output  1  one-cycle pulse on successful frame completion
cfg_err  output  1  one-cycle pulse on aborted, illegal or overrun frame
test_mode  input  1  scan test mode; forces pad controls to safe values
gpio_in  input  N_GPIO  pad input values (asynchronous to clk)
gpio_dir  output  N_GPIO  direction per pad, 1 = input, 0 = output
gpio_pullen  output  N_GPIO  pull enable per pad, 1 = enabled
gpio_out  output  N_GPIO  output data per pad

Behaviour:
- One clock. Reset is asynchronous and active-high. All flops clear on rst assertion, independent of clk.
- Reset values:
  - gpio_dir = all 1s (all pads input, safe).
  - gpio_pullen = 0. gpio_out = 0.
  - cfg_do = 0, cfg_done = 0, cfg_err = 0.
  - FSM in IDLE, bit counter = 0.
- Frame format, 32 bits, MSB first:
  - bit 31: rw (1 = read, 0 = write).
  - bits 30:29: sel (0 = DIR, 1 = PULLEN, 2 = OUT, 3 = IN, read-only).
  - bits 28:25: reserved, must be 0.
  - bits 24:0: data.
- FSM states:
  - IDLE: cfg_cs=1 → HDR, capture bit, cnt = 1.
  - HDR: shift header bits. On sampling the bit at cnt = 6, decode the header:
    - reserved bits ≠ 0, or write with sel = 3 → mark frame bad, go to WDATA (data is still consumed).
    - rw = 1 → RDATA; load the read shift register with a snapshot of the selected register.
    - otherwise → WDATA.
  - WDATA: shift 25 data bits. On sampling the bit at cnt = 31:
    - good frame: commit to the selected register; visible on the gpio_* outputs at the next clk edge. cfg_done pulses in that same cycle.
    - bad frame: no update; cfg_err pulses instead.
    - either way → WAIT.
  - RDATA: cfg_do is registered and presents data[24] in the cycle cnt = 7 is sampled, down to data[0] at cnt = 31. cfg_done pulses after cnt = 31 → WAIT.
  - WAIT: ignore cfg_di until cfg_cs = 0, then → IDLE. Any cfg_cs-high cycle in WAIT beyond the first produces no action. Exactly 32 bits per frame; the first extra bit raises a single cfg_err pulse (overrun).
- Abort: cfg_cs falling in HDR, WDATA or RDATA → IDLE with no register update and a one-cycle cfg_err pulse.
- cfg_cs must be low for at least 1 cycle between frames. Back-to-back frames without a gap are treated as overrun.
- cfg_do = 0 whenever not in RDATA.
- IN readback: gpio_in passes through a 2-flop synchroniser (reset 0). The snapshot is taken from synchronised values, so a pad change reaches readback after 2–3 cycles.
- Reads of DIR, PULLEN and OUT return register contents, not the test_mode-forced values.
- test_mode = 1 forces the gpio_* outputs to their reset values combinationally. Registers and the FSM keep operating; on test_mode = 0 the stored values reappear immediately.
- rst mid-frame: immediate return to IDLE and reset values. No done or err pulse.

Decomposition:
- Package gpio_cfg_pkg:
  - sel encodings SEL_DIR, SEL_PULLEN, SEL_OUT, SEL_IN.
  - FSM state enum (IDLE, HDR, WDATA, RDATA, WAIT).
  - constants N_GPIO, HDR_W, FRAME_W = 32.
  - reset value constants DIR_RST, PULLEN_RST, OUT_RST.
- One sub-module: gpio_sync2, a parameterised-width 2-flop synchroniser with asynchronous active-high reset.
- The remainder (shifter, counter, FSM, register bank) stays flat.

Test Plan:
- Reset, then observe → gpio_dir = 0x1FFFFFF, gpio_pullen = 0, gpio_out = 0, cfg_do = cfg_done = cfg_err = 0.
- Write frame to DIR with data 0x0000F0F → gpio_dir = 0x0000F0F one cycle after last bit; single cfg_done pulse; no cfg_err.
- Hold gpio_in = 0x1555555 for 4 cycles, then read IN → cfg_do streams 1,0,1,0… (25 bits, MSB first) over cnt 7..31; cfg_done pulse.
- Write OUT with sel = 3 or reserved = 0x5 → no register change; cfg_err pulse after bit 32. Drop cfg_cs after 20 bits of an OUT write → cfg_err, gpio_out unchanged.
- Hold cfg_cs for 33 bits on a PULLEN write of 0x1000001 → gpio_pullen = 0x1000001, then cfg_done followed by a single cfg_err pulse for the overrun.
- After writing DIR = 0, set test_mode = 1 → gpio_dir = 0x1FFFFFF; read DIR returns 0. Clear test_mode → gpio_dir = 0. Assert rst mid-read → cfg_do = 0, FSM in IDLE, no pulses.

Source files
------------

// File: rtl/gpio_cfg_pkg.sv
// Shared constants, register selects and FSM states for the GPIO configuration controller.
package gpio_cfg_pkg;

   localparam int N_GPIO  = 25;
   localparam int HDR_W   = 7;
   localparam int FRAME_W = HDR_W + N_GPIO;
   localparam int CNT_W   = $clog2(FRAME_W);

   localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_W - 1);

   localparam logic [N_GPIO-1:0] DIR_RST    = {N_GPIO{1'b1}};
   localparam logic [N_GPIO-1:0] PULLEN_RST = '0;
   localparam logic [N_GPIO-1:0] OUT_RST    = '0;

   typedef enum logic [1:0] {
      SEL_DIR    = 2'd0,
      SEL_PULLEN = 2'd1,
      SEL_OUT    = 2'd2,
      SEL_IN     = 2'd3
   } sel_t;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      WDATA,
      RDATA,
      WAIT
   } state_t;

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs, parameterised width.
module gpio_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/gpio_cfg_ctrl.sv
// Serial-frame configuration controller for the GPIO pad direction, pull-enable and output registers.
//   state | meaning
//   IDLE  | waiting for cfg_cs
//   HDR   | shifting 7 header bits, decode on the last one
//   WDATA | shifting 25 write data bits (or discarding a bad frame)
//   RDATA | streaming the read snapshot out on cfg_do
//   WAIT  | frame complete, waiting for cfg_cs to drop
module gpio_cfg_ctrl
   import gpio_cfg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_cs,
   input  logic              cfg_di,
   output logic              cfg_do,
   output logic              cfg_done,
   output logic              cfg_err,
   input  logic              test_mode,
   input  logic [N_GPIO-1:0] gpio_in,
   output logic [N_GPIO-1:0] gpio_dir,
   output logic [N_GPIO-1:0] gpio_pullen,
   output logic [N_GPIO-1:0] gpio_out
);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [N_GPIO-2:0] sr;
   logic [N_GPIO-2:0] rd_sr;
   sel_t              sel_q;
   logic              bad_q;
   logic              ovr_q;
   logic [N_GPIO-1:0] dir_q;
   logic [N_GPIO-1:0] pullen_q;
   logic [N_GPIO-1:0] out_q;
   logic [N_GPIO-1:0] in_sync;

   logic              done_nxt;
   logic              err_nxt;
   logic              commit;
   logic              decode;

   gpio_sync2 #(.W(N_GPIO)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gpio_in),
      .q   (in_sync)
   );

   // Header is complete once the current bit joins the six already shifted in.
   logic [HDR_W-1:0]  hdr;
   logic              hdr_rw;
   sel_t              hdr_sel;
   logic [3:0]        hdr_rsv;
   logic              hdr_bad;
   logic [N_GPIO-1:0] wdata;
   logic [N_GPIO-1:0] snap;

   assign hdr     = {sr[HDR_W-2:0], cfg_di};
   assign hdr_rw  = hdr[6];
   assign hdr_sel = sel_t'(hdr[5:4]);
   assign hdr_rsv = hdr[3:0];
   assign hdr_bad = (|hdr_rsv) || (!hdr_rw && (hdr_sel == SEL_IN));
   assign wdata   = {sr, cfg_di};

   always_comb begin
      snap = dir_q;
      unique case (hdr_sel)
         SEL_DIR:    snap = dir_q;
         SEL_PULLEN: snap = pullen_q;
         SEL_OUT:    snap = out_q;
         SEL_IN:     snap = in_sync;
         default:    snap = dir_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      commit    = 1'b0;
      decode    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cfg_cs) state_nxt = HDR;
         end
         HDR: begin
            if (!cfg_cs) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else if (cnt == CNT_HDR_LAST) begin
               decode    = 1'b1;
               state_nxt = (hdr_rw && !hdr_bad) ? RDATA : WDATA;
            end
         end
         WDATA: begin
            if (!cfg_cs) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = WAIT;
               if (bad_q) begin
                  err_nxt = 1'b1;
               end else begin
                  commit   = 1'b1;
                  done_nxt = 1'b1;
               end
            end
         end
         RDATA: begin
            if (!cfg_cs) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = WAIT;
               done_nxt  = 1'b1;
            end
         end
         WAIT: begin
            if (!cfg_cs)     state_nxt = IDLE;
            else if (!ovr_q) err_nxt   = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         sr       <= '0;
         rd_sr    <= '0;
         sel_q    <= SEL_DIR;
         bad_q    <= 1'b0;
         ovr_q    <= 1'b0;
         cfg_do   <= 1'b0;
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_done <= done_nxt;
         cfg_err  <= err_nxt;
         ovr_q    <= (state == WAIT) && (state_nxt == WAIT);
         if (cfg_cs) sr <= {sr[N_GPIO-3:0], cfg_di};
         if ((state_nxt == HDR) || (state_nxt == WDATA) || (state_nxt == RDATA))
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
         if (decode) begin
            sel_q <= hdr_sel;
            bad_q <= hdr_bad;
         end
         // cfg_do is driven one bit ahead of the sampled bit so data[0] lines up with cnt = 31.
         cfg_do <= 1'b0;
         if (decode && (state_nxt == RDATA)) begin
            cfg_do <= snap[N_GPIO-1];
            rd_sr  <= snap[N_GPIO-2:0];
         end else if ((state == RDATA) && (state_nxt == RDATA)) begin
            cfg_do <= rd_sr[N_GPIO-2];
            rd_sr  <= {rd_sr[N_GPIO-3:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q    <= DIR_RST;
         pullen_q <= PULLEN_RST;
         out_q    <= OUT_RST;
      end else if (commit) begin
         unique case (sel_q)
            SEL_DIR:    dir_q    <= wdata;
            SEL_PULLEN: pullen_q <= wdata;
            SEL_OUT:    out_q    <= wdata;
            default:    ;
         endcase
      end
   end

   assign gpio_dir    = test_mode ? DIR_RST    : dir_q;
   assign gpio_pullen = test_mode ? PULLEN_RST : pullen_q;
   assign gpio_out    = test_mode ? OUT_RST    : out_q;

endmodule

// File: tb/tb_gpio_cfg_ctrl.sv
// Randomised frame-level bench for gpio_cfg_ctrl against a behavioural register/frame model.
module tb_gpio_cfg_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_cs;
   logic        cfg_di;
   logic        cfg_do;
   logic        cfg_done;
   logic        cfg_err;
   logic        test_mode;
   logic [24:0] gpio_in;
   logic [24:0] gpio_dir;
   logic [24:0] gpio_pullen;
   logic [24:0] gpio_out;

   gpio_cfg_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_cs      (cfg_cs),
      .cfg_di      (cfg_di),
      .cfg_do      (cfg_do),
      .cfg_done    (cfg_done),
      .cfg_err     (cfg_err),
      .test_mode   (test_mode),
      .gpio_in     (gpio_in),
      .gpio_dir    (gpio_dir),
      .gpio_pullen (gpio_pullen),
      .gpio_out    (gpio_out)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [24:0] m_dir;
   logic [24:0] m_pull;
   logic [24:0] m_out;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_dir  = 25'h1FFFFFF;
      m_pull = 25'h0;
      m_out  = 25'h0;
   endtask

   task automatic chk_pads(input string tag);
      chk({tag, "_dir"},  32'(gpio_dir),    32'(test_mode ? 25'h1FFFFFF : m_dir));
      chk({tag, "_pull"}, 32'(gpio_pullen), 32'(test_mode ? 25'h0 : m_pull));
      chk({tag, "_out"},  32'(gpio_out),    32'(test_mode ? 25'h0 : m_out));
   endtask

   function automatic logic [31:0] mk(input logic rw, input logic [1:0] sel,
                                      input logic [3:0] rsv, input logic [24:0] data);
      return {rw, sel, rsv, data};
   endfunction

   // Drives cfg_cs high for nbits bits of word (extra bits random), then a 3-cycle gap.
   task automatic send_frame(input string tag, input logic [31:0] word, input int nbits);
      logic        rw      = word[31];
      logic [1:0]  sel     = word[30:29];
      logic [3:0]  rsv     = word[28:25];
      logic [24:0] data    = word[24:0];
      bit          bad     = (rsv != 4'h0) || (!rw && (sel == 2'd3));
      bit          rd_path = rw && (rsv == 4'h0);
      bit          good    = (nbits >= 32) && !bad;
      int          n_done  = 0;
      int          n_err   = 0;
      int          exp_err;
      logic        stray   = 1'b0;
      logic [24:0] rd      = '0;
      logic [24:0] exp_rd;
      logic [31:0] w       = word;
      case (sel)
         2'd0:    exp_rd = m_dir;
         2'd1:    exp_rd = m_pull;
         2'd2:    exp_rd = m_out;
         default: exp_rd = gpio_in;
      endcase
      exp_err = ((nbits < 32) || bad ? 1 : 0) + (nbits > 32 ? 1 : 0);
      for (int k = 0; k < nbits; k++) begin
         @(posedge clk); #1;
         cfg_cs = 1'b1;
         if (k < 32) begin
            cfg_di = w[31];
            w      = {w[30:0], 1'b0};
         end else begin
            cfg_di = 1'($urandom);
         end
         @(negedge clk);
         n_done += int'(cfg_done);
         n_err  += int'(cfg_err);
         if (rd_path && (k >= 7) && (k <= 31)) rd[31-k] = cfg_do;
         else if (cfg_do) stray = 1'b1;
      end
      @(posedge clk); #1;
      cfg_cs = 1'b0;
      cfg_di = 1'b0;
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         n_done += int'(cfg_done);
         n_err  += int'(cfg_err);
         if (cfg_do && !(p == 0 && rd_path && nbits >= 7 && nbits < 32)) stray = 1'b1;
         if (p == 0) begin
            if (good && !rw) begin
               case (sel)
                  2'd0:    m_dir  = data;
                  2'd1:    m_pull = data;
                  default: m_out  = data;
               endcase
            end
            chk_pads({tag, "_pads"});
         end
      end
      chk({tag, "_done"}, 32'(n_done), good ? 32'd1 : 32'd0);
      chk({tag, "_err"},  32'(n_err),  32'(exp_err));
      chk({tag, "_do_idle"}, 32'(stray), 32'd0);
      if (good && rw) chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
   endtask

   initial begin
      rst       = 1'b1;
      cfg_cs    = 1'b0;
      cfg_di    = 1'b0;
      test_mode = 1'b0;
      gpio_in   = 25'h0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_pads("reset");
      chk("reset_do",   32'(cfg_do),   32'd0);
      chk("reset_done", 32'(cfg_done), 32'd0);
      chk("reset_err",  32'(cfg_err),  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(negedge clk);

      send_frame("wr_dir", mk(1'b0, 2'd0, 4'h0, 25'h0000F0F), 32);

      gpio_in = 25'h1555555;
      repeat (4) @(negedge clk);
      send_frame("rd_in", mk(1'b1, 2'd3, 4'h0, 25'h0), 32);

      send_frame("wr_sel3", mk(1'b0, 2'd3, 4'h0, 25'h0ABCDEF), 32);
      send_frame("wr_rsv",  mk(1'b0, 2'd2, 4'h5, 25'h0ABCDEF), 32);
      send_frame("wr_abort", mk(1'b0, 2'd2, 4'h0, 25'h1234567), 20);
      send_frame("wr_ovr", mk(1'b0, 2'd1, 4'h0, 25'h1000001), 33);
      send_frame("rd_pull", mk(1'b1, 2'd1, 4'h0, 25'h0), 32);

      send_frame("wr_dir0", mk(1'b0, 2'd0, 4'h0, 25'h0), 32);
      test_mode = 1'b1;
      #1 chk_pads("tm_on");
      send_frame("tm_rd_dir", mk(1'b1, 2'd0, 4'h0, 25'h0), 32);
      test_mode = 1'b0;
      #1 chk_pads("tm_off");

      for (int i = 0; i < 80; i++) begin
         logic        rw  = 1'($urandom);
         logic [1:0]  sel = 2'($urandom);
         logic [3:0]  rsv = ($urandom_range(5, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
         int          r   = int'($urandom_range(9, 0));
         int          nb;
         nb = (r < 6) ? 32 : (r < 8) ? 32 + int'($urandom_range(2, 1)) : int'($urandom_range(31, 1));
         if ($urandom_range(3, 0) == 0) begin
            gpio_in = 25'($urandom);
            repeat (4) @(negedge clk);
         end
         test_mode = ($urandom_range(4, 0) == 0);
         #1;
         send_frame($sformatf("rnd%0d", i), mk(rw, sel, rsv, 25'($urandom)), nb);
      end
      test_mode = 1'b0;

      // Reset in the middle of a read burst.
      send_frame("pre_rst_wr", mk(1'b0, 2'd2, 4'h0, 25'h1FFFFFF), 32);
      begin
         logic [31:0] w = mk(1'b1, 2'd2, 4'h0, 25'h0);
         int          pulses = 0;
         for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            cfg_cs = 1'b1;
            cfg_di = w[31];
            w      = {w[30:0], 1'b0};
         end
         @(negedge clk);
         #2 rst = 1'b1;
         #1;
         model_reset();
         chk("rst_mid_do", 32'(cfg_do), 32'd0);
         chk_pads("rst_mid");
         cfg_cs = 1'b0;
         for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            pulses += int'(cfg_done) + int'(cfg_err);
         end
         @(posedge clk); #1;
         rst = 1'b0;
         for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            pulses += int'(cfg_done) + int'(cfg_err) + int'(cfg_do);
         end
         chk("rst_mid_pulses", 32'(pulses), 32'd0);
      end
      send_frame("post_rst_rd", mk(1'b1, 2'd0, 4'h0, 25'h0), 32);
      send_frame("post_rst_wr", mk(1'b0, 2'd2, 4'h0, 25'h0C0FFEE), 32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
